// File: rtl/adc_pkg.sv
// Shared state encoding, mode codes and sizing helpers for the ADC sampler.
package adc_pkg;

    localparam int ADC_BITS = 10;

    typedef enum logic [2:0] {IDLE, START, WAIT, CAPTURE, GAP} sampler_state_t;

    localparam logic [1:0] MODE_CH0 = 2'b00;
    localparam logic [1:0] MODE_CH1 = 2'b01;
    localparam logic [1:0] MODE_ALT = 2'b10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/adc_accum.sv
// Per-channel boxcar averager: sums 2**AVG_LOG2 captures, then publishes the
// truncated mean with a one-cycle valid pulse.
module adc_accum
    import adc_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic                sclk,
    input  logic                reset,
    input  logic                clr,
    input  logic                add,
    input  logic [ADC_BITS-1:0] sample,
    output logic [ADC_BITS-1:0] avg,
    output logic                valid
);

    localparam int SW = ADC_BITS + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [SW-1:0]       r_sum;
    logic [CW-1:0]       r_cnt;
    logic [ADC_BITS-1:0] r_avg;
    logic                r_valid;
    logic [SW-1:0]       w_total;
    logic                w_done;

    // The completing sample is folded in directly so the average is ready one edge later.
    assign w_total = r_sum + SW'(sample);
    assign w_done  = (r_cnt == CW'((1 << AVG_LOG2) - 1));

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_sum   <= '0;
            r_cnt   <= '0;
            r_avg   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (clr) begin
                r_sum <= '0;
                r_cnt <= '0;
            end else if (add) begin
                if (w_done) begin
                    r_avg   <= w_total[SW-1:AVG_LOG2];
                    r_valid <= 1'b1;
                    r_sum   <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_sum <= w_total;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign avg   = r_avg;
    assign valid = r_valid;

endmodule

// File: rtl/adc_sampler.sv
// Conversion sequencer for the SPI ADC: issues start/channel, waits out the
// frame, captures the result and steers it into per-channel averagers.
module adc_sampler
    import adc_pkg::*;
#(
    parameter int AVG_LOG2    = 2,
    parameter int START_HOLD  = 2,
    parameter int CONV_CYCLES = 17,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                sclk,
    input  logic                reset,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [ADC_BITS-1:0] adc_voltage,
    output logic                adc_start,
    output logic                adc_channel,
    output logic [ADC_BITS-1:0] ch0_avg,
    output logic [ADC_BITS-1:0] ch1_avg,
    output logic                ch0_valid,
    output logic                ch1_valid,
    output logic                busy
);

    localparam int CNT_MAX = max3(START_HOLD, CONV_CYCLES, GAP_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    sampler_state_t r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic           r_chan;
    logic           r_next_ch;
    logic [1:0]     r_mode;
    logic           w_enter_start;
    logic           w_from_idle;
    logic [1:0]     w_mode_n;
    logic           w_chan_sel;
    logic           w_clr;

    logic [1:0][ADC_BITS-1:0] w_avg;
    logic [1:0]               w_vld;
    logic [1:0]               w_add;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_enter_start = 1'b0;
        w_from_idle   = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt   = START;
                    w_cnt_nxt     = '0;
                    w_enter_start = 1'b1;
                    w_from_idle   = 1'b1;
                end
            end
            START: begin
                if (r_cnt == CW'(START_HOLD - 1)) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            WAIT: begin
                if (r_cnt == CW'(CONV_CYCLES - 1)) begin
                    w_state_nxt = CAPTURE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            CAPTURE: begin
                w_cnt_nxt = '0;
                // With no gap configured, the run/stop decision moves up to CAPTURE.
                if (GAP_CYCLES == 0) begin
                    w_state_nxt   = en ? START : IDLE;
                    w_enter_start = en;
                end else begin
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                if (r_cnt == CW'(GAP_CYCLES - 1)) begin
                    w_cnt_nxt     = '0;
                    w_state_nxt   = en ? START : IDLE;
                    w_enter_start = en;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_mode_n = mode[1] ? MODE_ALT : mode;

    // Alternate mode always opens a run on CH0, then ping-pongs per capture.
    always_comb begin
        w_chan_sel = 1'b0;
        if (w_mode_n == MODE_CH1)
            w_chan_sel = 1'b1;
        else if (w_mode_n == MODE_ALT)
            w_chan_sel = w_from_idle ? 1'b0 : r_next_ch;
    end

    assign w_clr = w_enter_start && (w_mode_n != r_mode);

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_chan    <= 1'b0;
            r_next_ch <= 1'b0;
            r_mode    <= MODE_CH0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_enter_start) begin
                r_chan <= w_chan_sel;
                r_mode <= w_mode_n;
            end
            if (r_state == CAPTURE)
                r_next_ch <= ~r_chan;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_ch
        assign w_add[g] = (r_state == CAPTURE) && (r_chan == 1'(g));
        adc_accum #(.AVG_LOG2(AVG_LOG2)) u_acc (
            .sclk   (sclk),
            .reset  (reset),
            .clr    (w_clr),
            .add    (w_add[g]),
            .sample (adc_voltage),
            .avg    (w_avg[g]),
            .valid  (w_vld[g])
        );
    end

    assign adc_start   = (r_state == START);
    assign adc_channel = r_chan;
    assign busy        = (r_state != IDLE);
    assign ch0_avg     = w_avg[0];
    assign ch1_avg     = w_avg[1];
    assign ch0_valid   = w_vld[0];
    assign ch1_valid   = w_vld[1];

endmodule

// File: tb/tb_adc_sampler.sv
// Bench for adc_sampler: behavioural SPI ADC plus a conversion-level averaging
// scoreboard, table vectors, hand-written corner sequences and random runs.
module tb_adc_sampler;

    localparam int AVG   = 2;
    localparam int SH    = 2;
    localparam int CONV  = 17;
    localparam int GAPC  = 4;
    localparam int LAT   = SH + CONV + 1;
    localparam int PER   = SH + CONV + 1 + GAPC;

    logic       sclk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [9:0] adc_voltage = 10'd0;

    logic       adc_start, adc_channel, ch0_valid, ch1_valid, busy;
    logic [9:0] ch0_avg, ch1_avg;
    logic       p_start, p_channel, p0_valid, p1_valid, p_busy;
    logic [9:0] p0_avg, p1_avg;

    adc_sampler #(.AVG_LOG2(AVG), .START_HOLD(SH), .CONV_CYCLES(CONV), .GAP_CYCLES(GAPC)) dut (
        .sclk(sclk), .reset(reset), .en(en), .mode(mode), .adc_voltage(adc_voltage),
        .adc_start(adc_start), .adc_channel(adc_channel), .ch0_avg(ch0_avg), .ch1_avg(ch1_avg),
        .ch0_valid(ch0_valid), .ch1_valid(ch1_valid), .busy(busy)
    );

    // Pass-through instance running in lockstep on the same bus.
    adc_sampler #(.AVG_LOG2(0), .START_HOLD(SH), .CONV_CYCLES(CONV), .GAP_CYCLES(GAPC)) dut_pt (
        .sclk(sclk), .reset(reset), .en(en), .mode(mode), .adc_voltage(adc_voltage),
        .adc_start(p_start), .adc_channel(p_channel), .ch0_avg(p0_avg), .ch1_avg(p1_avg),
        .ch0_valid(p0_valid), .ch1_valid(p1_valid), .busy(p_busy)
    );

    always #5 sclk = ~sclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural ADC + reference model ----------------
    typedef struct {
        int         cyc;
        logic       ch;
        logic [9:0] avg;
    } ev_t;

    ev_t        qe[2][$];
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    int         msum[2];
    int         mcnt[2];
    logic [1:0] last_mode = 2'd0;
    logic       alt_next = 1'b0;
    int         cyc = 0;
    int         n_starts = 0;
    int         frame_cnt = -1;
    int         hi_len = 0;
    int         last_start = 0;
    logic [9:0] cur_code = 10'd0;
    logic       prev_start = 1'b0;
    logic       prev_busy = 1'b0;

    task automatic mon_valid(input int w, input logic v0, input logic v1,
                             input logic [9:0] a0, input logic [9:0] a1);
        ev_t e;
        if (v0 && v1) begin
            n_tests++; n_fail++;
            $display("FAIL dut%0d_both_valid: got both valids high at cycle %0d, required at most one", w, cyc);
        end
        while (qe[w].size() > 0 && qe[w][0].cyc < cyc) begin
            e = qe[w].pop_front();
            n_tests++; n_fail++;
            $display("FAIL dut%0d_missed_valid: got no pulse at cycle %0d, required ch%0d avg %0d", w, e.cyc, e.ch, e.avg);
        end
        if (v0 || v1) begin
            if (qe[w].size() == 0 || qe[w][0].cyc != cyc) begin
                n_tests++; n_fail++;
                $display("FAIL dut%0d_unexpected_valid: got pulse on ch%0d at cycle %0d, required none", w, v1, cyc);
            end else begin
                e = qe[w].pop_front();
                check($sformatf("dut%0d_valid_ch", w), v1, e.ch);
                check($sformatf("dut%0d_avg", w), v1 ? a1 : a0, e.avg);
            end
        end
    endtask

    always @(negedge sclk) begin
        logic [1:0] m;
        logic       ch, first;
        logic [9:0] code;
        cyc++;
        if (reset) begin
            qe[0].delete(); qe[1].delete(); q0.delete(); q1.delete();
            for (int i = 0; i < 2; i++) begin msum[i] = 0; mcnt[i] = 0; end
            last_mode  = 2'd0;
            alt_next   = 1'b0;
            frame_cnt  = -1;
            prev_start = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            mon_valid(0, ch0_valid, ch1_valid, ch0_avg, ch1_avg);
            mon_valid(1, p0_valid, p1_valid, p0_avg, p1_avg);
            if (frame_cnt >= 0) begin
                frame_cnt++;
                if (frame_cnt == 16) begin
                    adc_voltage = cur_code;
                    frame_cnt   = -1;
                end
            end
            if (adc_start && !prev_start) begin
                m     = mode[1] ? 2'd2 : mode;
                first = !prev_busy;
                if (!first) check("start_spacing", cyc - last_start, PER);
                last_start = cyc;
                n_starts++;
                if (m != last_mode) begin
                    for (int i = 0; i < 2; i++) begin msum[i] = 0; mcnt[i] = 0; end
                end
                last_mode = m;
                ch = (m == 2'd0) ? 1'b0 : (m == 2'd1) ? 1'b1 : (first ? 1'b0 : alt_next);
                alt_next = ~ch;
                check("adc_channel", adc_channel, ch);
                check("adc_channel_pt", p_channel, ch);
                if (!ch && q0.size() > 0)     code = q0.pop_front();
                else if (ch && q1.size() > 0) code = q1.pop_front();
                else                          code = 10'($urandom_range(0, 1023));
                cur_code    = code;
                adc_voltage = code ^ 10'h2AA;
                frame_cnt   = 0;
                hi_len      = 1;
                msum[ch] += int'(code);
                mcnt[ch]++;
                if (mcnt[ch] == (1 << AVG)) begin
                    qe[0].push_back('{cyc + LAT, ch, 10'(msum[ch] / (1 << AVG))});
                    msum[ch] = 0;
                    mcnt[ch] = 0;
                end
                qe[1].push_back('{cyc + LAT, ch, code});
            end else if (adc_start) begin
                hi_len++;
            end
            if (!adc_start && prev_start) check("start_width", hi_len, SH);
            prev_start = adc_start;
            prev_busy  = busy;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_starts(input int target);
        int t;
        t = 0;
        while (n_starts < target && t < 1000) begin
            @(negedge sclk); #1;
            t++;
        end
        check("start_seen", n_starts, target);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 200) begin
            @(negedge sclk); #1;
            t++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic run_convs(input int n);
        int base;
        base = n_starts;
        en = 1'b1;
        wait_starts(base + n);
        en = 1'b0;
        wait_idle();
    endtask

    typedef struct packed {
        logic [1:0]      mode;
        logic [3:0]      nconv;
        logic [3:0][9:0] c0;
        logic [3:0][9:0] c1;
        logic            chk0;
        logic            chk1;
        logic [9:0]      e0;
        logic [9:0]      e1;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, k;

        vecs[0] = '{mode:2'd0, nconv:4'd4, c0:{10'd112, 10'd108, 10'd104, 10'd100}, c1:'0,
                    chk0:1'b1, chk1:1'b0, e0:10'd106, e1:10'd0};
        vecs[1] = '{mode:2'd0, nconv:4'd4, c0:{10'd0, 10'd1, 10'd1, 10'd1}, c1:'0,
                    chk0:1'b1, chk1:1'b0, e0:10'd0, e1:10'd0};
        vecs[2] = '{mode:2'd1, nconv:4'd4, c0:'0, c1:{10'd41, 10'd30, 10'd20, 10'd10},
                    chk0:1'b0, chk1:1'b1, e0:10'd0, e1:10'd25};
        vecs[3] = '{mode:2'd2, nconv:4'd8, c0:{4{10'h3FF}}, c1:{4{10'h001}},
                    chk0:1'b1, chk1:1'b1, e0:10'h3FF, e1:10'h001};
        vecs[4] = '{mode:2'd3, nconv:4'd8, c0:{10'd3, 10'd0, 10'd0, 10'd0}, c1:{10'd2, 10'd3, 10'd3, 10'd3},
                    chk0:1'b1, chk1:1'b1, e0:10'd0, e1:10'd2};
        vecs[5] = '{mode:2'd1, nconv:4'd4, c0:'0, c1:{10'd1020, 10'd1021, 10'd1022, 10'd1023},
                    chk0:1'b0, chk1:1'b1, e0:10'd0, e1:10'd1021};

        // reset state
        repeat (3) @(negedge sclk);
        reset = 1'b0;
        #1;
        check("rst_adc_start", adc_start, 0);
        check("rst_adc_channel", adc_channel, 0);
        check("rst_busy", busy, 0);
        check("rst_ch0_avg", ch0_avg, 0);
        check("rst_ch1_avg", ch1_avg, 0);
        check("rst_valids", {ch0_valid, ch1_valid}, 0);
        repeat (5) @(negedge sclk);
        #1;
        check("idle_without_en", busy, 0);

        // table vectors
        for (int v = 0; v < 6; v++) begin
            q0.delete(); q1.delete();
            for (int i = 0; i < 4; i++) begin
                q0.push_back(vecs[v].c0[i]);
                q1.push_back(vecs[v].c1[i]);
            end
            mode = vecs[v].mode;
            run_convs(int'(vecs[v].nconv));
            repeat (2) @(negedge sclk);
            #1;
            if (vecs[v].chk0) check($sformatf("vec%0d_ch0_avg", v), ch0_avg, vecs[v].e0);
            if (vecs[v].chk1) check($sformatf("vec%0d_ch1_avg", v), ch1_avg, vecs[v].e1);
        end

        // en dropped mid-WAIT; partial accumulation resumes on restart
        q0.delete(); q1.delete();
        q0.push_back(10'd400); q0.push_back(10'd402); q0.push_back(10'd404); q0.push_back(10'd410);
        mode = 2'd0;
        base = n_starts;
        en = 1'b1;
        wait_starts(base + 2);
        repeat (6) @(negedge sclk);
        #1;
        check("busy_in_wait", busy, 1);
        en = 1'b0;
        k = 0;
        while (busy && k < 100) begin
            @(negedge sclk); #1;
            k++;
        end
        check("busy_fall_after_gap", k, PER - 6);
        run_convs(2);
        repeat (2) @(negedge sclk);
        #1;
        check("resume_ch0_avg", ch0_avg, 404);

        // async reset mid-WAIT
        q0.delete();
        mode = 2'd0;
        base = n_starts;
        en = 1'b1;
        wait_starts(base + 1);
        repeat (8) @(negedge sclk);
        #3;
        reset = 1'b1;
        #1;
        check("mrst_adc_start", adc_start, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ch0_avg", ch0_avg, 0);
        check("mrst_ch1_avg", ch1_avg, 0);
        check("mrst_valids", {ch0_valid, ch1_valid, p0_valid, p1_valid}, 0);
        en = 1'b0;
        repeat (3) @(negedge sclk);
        reset = 1'b0;
        repeat (10) @(negedge sclk);
        #1;
        check("mrst_stays_idle", {busy, adc_start}, 0);

        // randomized runs against the scoreboard
        for (int r = 0; r < 14; r++) begin
            q0.delete(); q1.delete();
            mode = 2'($urandom_range(0, 3));
            run_convs($urandom_range(1, 9));
            repeat ($urandom_range(0, 3)) @(negedge sclk);
            #1;
        end

        repeat (30) @(negedge sclk);
        #1;
        check("pending_avg_events", qe[0].size(), 0);
        check("pending_pt_events", qe[1].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
